wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the 8-bit, 4-stage teaching pipeline. It sits directly downstream of the EX-stage ALU and latches each ALU result in an EX/WB pipeline register. It commits the result to an 8-entry register file and serves two combinational read ports to the ID stage. It also exposes the in-flight write-back value as a forwarding source for EX, and keeps a retire counter and a sticky halt flag.

## Interface
Parameters:
- `DW`, 8, data width of registers and ALU results
- `AW`, 3, register address width (2**AW registers)

Ports:
- `clk`  in  1  single clock, rising edge
- `rstn`  in  1  asynchronous reset, active-low
- `ex_valid`  in  1  EX stage presents a valid result this cycle
- `ex_opcode`  in  4  opcode of the EX instruction
- `ex_rd`  in  AW  destination register
- `ex_result`  in  DW  ALU result
- `rs1_addr`, `rs2_addr`  in  AW  ID read addresses
- `rs1_data`, `rs2_data`  out  DW  ID read data (combinational)
- `fwd_valid`  out  1  WB latch holds a committing write
- `fwd_rd`  out  AW  destination of that write
- `fwd_data`  out  DW  data of that write
- `retired`  out  8  count of committed writes, wraps
- `halted`  out  1  sticky; set by HALT opcode

## Operation
- EX/WB latch holds `wb_valid`, `wb_opcode`, `wb_rd` and `wb_data`.
  - On each rising edge with `halted`=0, the latch captures `ex_*`.
  - With `halted`=1, `wb_valid` is loaded with 0 and the other fields hold.
- Commit condition `wb_we` = `wb_valid` & (`wb_opcode` != 4'h0 NOP) & (`wb_opcode` != 4'hF HALT) & (`wb_rd` != 0).
- On the rising edge where `wb_we`=1:
  - `regs[wb_rd]` <= `wb_data`.
  - `retired` <= `retired`+1 (mod 256; 255 wraps to 0).
- Register r0 reads as 0 at all times and is never written.
- HALT: `wb_valid` & `wb_opcode`==4'hF sets `halted` on the next edge. Only reset clears it. Once set, the pipeline drains nothing further into the regfile.
- Forwarding outputs:
  - `fwd_valid` = `wb_we`.
  - `fwd_rd` = `wb_rd` and `fwd_data` = `wb_data` always, so they are don't-care when `fwd_valid`=0.
- Read ports: `rsN_data` = 0 if `rsN_addr`==0. Otherwise it is the value from the bypass path (see Configuration), else `regs[rsN_addr]`.
- Both read ports are fully independent. The same address on both ports returns identical data.

## Timing
- Reset (async assert, sync deassert is upstream's job):
  - all `regs`=0
  - `wb_valid`=0, `wb_opcode`=0, `wb_rd`=0, `wb_data`=0
  - `retired`=0, `halted`=0
  - hence `fwd_valid`=0, `rs1_data`=`rs2_data`=0
- Latency:
  - EX presents in cycle N → `fwd_*` valid in cycle N+1 → regfile updated at the edge ending N+1 → plain read sees it in N+2.
- Back-to-back writes to the same rd in consecutive cycles: each commits in order, the last wins, and `retired` increments once per commit.
- `ex_valid` with NOP, HALT or rd=0: no regfile write, no `retired` increment. `fwd_valid`=0.
- HALT followed immediately by a valid write in cycle N+1:
  - `halted` rises at the edge ending N+1, so the following instruction is captured (captured in N+1 while `halted` was still 0) and commits normally.
  - Anything presented from N+2 on is dropped.
- Reset asserted mid-operation: outputs take reset values immediately (asynchronously). An in-flight WB entry is discarded without writing.

## Configuration
- `WB_BYPASS_EN` defined:
  - when `wb_we`=1 and `rsN_addr`==`wb_rd`, `rsN_data`=`wb_data` in the same cycle (write-before-read).
  - This gives a 1-cycle EX→ID visibility.
- Undefined:
  - no bypass; `rsN_data` always reflects the regfile contents.
  - ID sees the new value one cycle later (N+2), and EX must rely on `fwd_*`.

## Test plan
- Reset, then write r3=8'h5A (opcode 4'h1):
  - `fwd_valid`=1, `fwd_rd`=3, `fwd_data`=8'h5A one cycle later.
  - `rs1_addr`=3 returns 8'h5A from the following cycle.
  - `retired`=1.
- Write to r0 with 8'hFF, and a NOP targeting r2 with 8'h11: both read back 0, `retired` unchanged, `fwd_valid`=0.
- Same-cycle read of the committing register (r5=8'hA7):
  - with `WB_BYPASS_EN`, `rs2_data`=8'hA7 during the WB cycle;
  - without it, `rs2_data`=old value (0), then 8'hA7 the next cycle.
- HALT, then writes r1=8'h01, r2=8'h02 in the two following cycles:
  - `halted`=1 after two edges, r1=8'h01 committed;
  - r2 remains 0, and `halted` stays 1 until reset.
- 256 consecutive valid writes to r4: `retired` goes 255→0, r4 holds the last data.
- Assert `rstn`=0 while `wb_valid`=1 with r6=8'h3C pending: outputs go to 0 immediately, r6 reads 0 after reset release.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: EX/WB latch, 2**AW-entry regfile with two read ports, forwarding, retire counter, sticky halt; define WB_BYPASS_EN for same-cycle write-before-read bypass
module wb_stage #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ex_valid,
  input  logic [3:0]    ex_opcode,
  input  logic [AW-1:0] ex_rd,
  input  logic [DW-1:0] ex_result,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic [DW-1:0] rs1_data,
  output logic [DW-1:0] rs2_data,
  output logic          fwd_valid,
  output logic [AW-1:0] fwd_rd,
  output logic [DW-1:0] fwd_data,
  output logic [7:0]    retired,
  output logic          halted
);
  localparam int NR = 2**AW;
  logic          wb_valid_q, wb_valid_d;
  logic [3:0]    wb_opcode_q, wb_opcode_d;
  logic [AW-1:0] wb_rd_q, wb_rd_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic [7:0]    retired_q, retired_d;
  logic          halted_q, halted_d;
  logic [DW-1:0] regs_q [NR];
  logic [DW-1:0] regs_d [NR];
  logic          wb_we, byp1, byp2;
  // next state: latch follows EX until halted, a commit writes the regfile and bumps the counter
  always_comb begin
    wb_we       = wb_valid_q && wb_opcode_q != 4'h0 && wb_opcode_q != 4'hF && wb_rd_q != '0;
    wb_valid_d  = ex_valid & ~halted_q;
    wb_opcode_d = halted_q ? wb_opcode_q : ex_opcode;
    wb_rd_d     = halted_q ? wb_rd_q : ex_rd;
    wb_data_d   = halted_q ? wb_data_q : ex_result;
    halted_d    = halted_q | (wb_valid_q & (wb_opcode_q == 4'hF));
    retired_d   = retired_q + {7'd0, wb_we};
    regs_d      = regs_q;
    if (wb_we) regs_d[wb_rd_q] = wb_data_q;
  end
  // read ports: r0 is hardwired zero, optional bypass of the write committing this cycle
  always_comb begin
`ifdef WB_BYPASS_EN
    byp1     = wb_we && rs1_addr == wb_rd_q;
    byp2     = wb_we && rs2_addr == wb_rd_q;
`else
    byp1     = 1'b0;
    byp2     = 1'b0;
`endif
    rs1_data = rs1_addr == '0 ? '0 : byp1 ? wb_data_q : regs_q[rs1_addr];
    rs2_data = rs2_addr == '0 ? '0 : byp2 ? wb_data_q : regs_q[rs2_addr];
  end
  // state registers; reset discards any in-flight write and clears the regfile
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_valid_q  <= 1'b0;
      wb_opcode_q <= '0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      retired_q   <= '0;
      halted_q    <= 1'b0;
      for (int i = 0; i < NR; i++) regs_q[i] <= '0;
    end else begin
      wb_valid_q  <= wb_valid_d;
      wb_opcode_q <= wb_opcode_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      retired_q   <= retired_d;
      halted_q    <= halted_d;
      regs_q      <= regs_d;
    end
  end
  assign fwd_valid = wb_we;
  assign fwd_rd    = wb_rd_q;
  assign fwd_data  = wb_data_q;
  assign retired   = retired_q;
  assign halted    = halted_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage; expected commits queued at drive time, popped when fwd_valid appears
module tb_wb_stage;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       ex_valid = 1'b0;
  logic [3:0] ex_opcode = '0;
  logic [2:0] ex_rd = '0;
  logic [7:0] ex_result = '0;
  logic [2:0] rs1_addr = '0;
  logic [2:0] rs2_addr = '0;
  logic [7:0] rs1_data, rs2_data, fwd_data, retired;
  logic [2:0] fwd_rd;
  logic       fwd_valid, halted;
  typedef struct {
    logic [2:0] rd;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;
  wb_stage dut (
    .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
    .ex_result(ex_result), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retired(retired), .halted(halted)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive(input bit v, input logic [3:0] op, input logic [2:0] rd, input logic [7:0] d, input bit commits);
    @(posedge clk);
    #1;
    ex_valid = v;
    ex_opcode = op;
    ex_rd = rd;
    ex_result = d;
    if (commits) sb.push_back('{rd, d});
  endtask
  task automatic idle();
    drive(1'b0, 4'h0, 3'd0, 8'h00, 1'b0);
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
    chk(tag, sb.size(), 0);
  endtask
  always @(negedge clk) begin
    if (rstn && fwd_valid) begin
      if (sb.size() == 0) chk("fwd_unexpected", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("fwd_rd", int'(fwd_rd), int'(e.rd));
        chk("fwd_data", int'(fwd_data), int'(e.data));
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rs1_addr = 3'd3;
    rs2_addr = 3'd5;
    repeat (2) @(negedge clk);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_retired", retired, 0);
    chk("rst_halted", halted, 0);
    chk("rst_rs1", rs1_data, 0);
    rstn = 1'b1;
    drive(1'b1, 4'h1, 3'd3, 8'h5A, 1'b1);
    idle();
    @(negedge clk);
    chk("fwd_cycle_valid", fwd_valid, 1);
`ifdef WB_BYPASS_EN
    chk("r3_wb_cycle", rs1_data, 8'h5A);
`else
    chk("r3_wb_cycle", rs1_data, 8'h00);
`endif
    idle();
    @(negedge clk);
    chk("r3_read", rs1_data, 8'h5A);
    chk("retired_1", retired, 1);
    drive(1'b1, 4'h1, 3'd0, 8'hFF, 1'b0);
    drive(1'b1, 4'h0, 3'd2, 8'h11, 1'b0);
    @(negedge clk);
    chk("r0_write_fwd", fwd_valid, 0);
    idle();
    @(negedge clk);
    chk("nop_fwd", fwd_valid, 0);
    rs1_addr = 3'd0;
    rs2_addr = 3'd2;
    idle();
    @(negedge clk);
    chk("r0_read", rs1_data, 0);
    chk("r2_nop_read", rs2_data, 0);
    chk("retired_unchanged", retired, 1);
    rs2_addr = 3'd5;
    drive(1'b1, 4'h2, 3'd5, 8'hA7, 1'b1);
    idle();
    @(negedge clk);
`ifdef WB_BYPASS_EN
    chk("r5_wb_cycle", rs2_data, 8'hA7);
`else
    chk("r5_wb_cycle", rs2_data, 8'h00);
`endif
    idle();
    @(negedge clk);
    chk("r5_read", rs2_data, 8'hA7);
    chk("retired_2", retired, 2);
    drain("sb_drain_basic");
    drive(1'b1, 4'hF, 3'd7, 8'hEE, 1'b0);
    drive(1'b1, 4'h1, 3'd1, 8'h01, 1'b1);
    @(negedge clk);
    chk("halt_not_yet", halted, 0);
    chk("halt_fwd", fwd_valid, 0);
    drive(1'b1, 4'h1, 3'd2, 8'h02, 1'b0);
    @(negedge clk);
    chk("halt_set", halted, 1);
    drive(1'b1, 4'h3, 3'd5, 8'h33, 1'b0);
    idle();
    idle();
    rs1_addr = 3'd1;
    rs2_addr = 3'd2;
    @(negedge clk);
    chk("halt_r1", rs1_data, 8'h01);
    chk("halt_r2", rs2_data, 8'h00);
    chk("halt_retired", retired, 3);
    rs2_addr = 3'd5;
    repeat (5) idle();
    @(negedge clk);
    chk("halt_r5_kept", rs2_data, 8'hA7);
    chk("halt_sticky", halted, 1);
    drain("sb_drain_halt");
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_clears_halt", halted, 0);
    chk("rst_clears_r1", rs1_data, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 256; i++) drive(1'b1, 4'h4, 3'd4, 8'(i) ^ 8'h5A, 1'b1);
    rs1_addr = 3'd4;
    idle();
    @(negedge clk);
    chk("retired_255", retired, 255);
    idle();
    @(negedge clk);
    chk("retired_wrap", retired, 0);
    chk("r4_last", rs1_data, 8'hA5);
    drain("sb_drain_wrap");
    drive(1'b1, 4'h1, 3'd6, 8'h3C, 1'b1);
    idle();
    @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("async_fwd_valid", fwd_valid, 0);
    chk("async_fwd_data", fwd_data, 0);
    chk("async_r4", rs1_data, 0);
    @(negedge clk);
    rstn = 1'b1;
    rs1_addr = 3'd6;
    idle();
    idle();
    @(negedge clk);
    chk("r6_discarded", rs1_data, 0);
    chk("retired_after_rst", retired, 0);
    chk("sb_final", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
